sc_player_move_ctrl: RTL and testbench

//  Parametrised player-movement controller for the board-game datapath (frog matrix). Decodes five active-low

---
 rtl/sc_player_pkg.sv | 43 ++++
 rtl/sc_repeat_timer.sv | 37 +++
 rtl/sc_player_move_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sc_player_move_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sc_player_pkg.sv
// Shared types for the frog-matrix player controller: FSM states, captured-button codes
// and the shift-selection encodings driven to the player matrix.
package sc_player_pkg;

    typedef enum logic [3:0] {
        RESET,
        START,
        CHECK,
        INIT,
        UP,
        DOWN,
        LEFT,
        RIGHT,
        HOLD
    } playerState_e;

    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_START,
        BTN_UP,
        BTN_DOWN,
        BTN_LEFT,
        BTN_RIGHT
    } playerBtn_e;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;

    // Maps a movement button onto the state that issues its command.
    function automatic playerState_e moveState(input playerBtn_e btn);
        playerState_e result;
        case (btn)
            BTN_UP:    result = UP;
            BTN_DOWN:  result = DOWN;
            BTN_LEFT:  result = LEFT;
            BTN_RIGHT: result = RIGHT;
            default:   result = HOLD;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sc_repeat_timer.sv
// Counts cycles spent holding a move button; raises done once the auto-repeat interval has elapsed.
module sc_repeat_timer #(
    parameter int REPEAT_CYCLES = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic done_o
);

    localparam int CW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = (REPEAT_CYCLES > 0) ? CW'(REPEAT_CYCLES - 1) : '0;

    logic [CW-1:0] countQ, countD;

    // The count parks on its terminal value instead of wrapping, so done stays stable until cleared.
    assign done_o = (REPEAT_CYCLES > 0) && (countQ == LAST);

    always_comb begin
        countD = countQ;
        if (clear_i) begin
            countD = '0;
        end else if (enable_i && !done_o) begin
            countD = countQ + CW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            countQ <= '0;
        end else begin
            countQ <= countD;
        end
    end

endmodule

// File: rtl/sc_player_move_ctrl.sv
// Player-movement controller: turns active-low buttons into one-cycle matrix shift commands,
// tracking the player position so that no move ever leaves the board.
module sc_player_move_ctrl
    import sc_player_pkg::*;
#(
    parameter int ROWS          = 8,
    parameter int COLS          = 8,
    parameter int START_COL     = 3,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic                     SC_PLAYERMOVE_CLOCK_50,
    input  logic                     SC_PLAYERMOVE_RESET_InHigh,
    input  logic                     SC_PLAYERMOVE_startButton_InLow,
    input  logic                     SC_PLAYERMOVE_upButton_InLow,
    input  logic                     SC_PLAYERMOVE_downButton_InLow,
    input  logic                     SC_PLAYERMOVE_leftButton_InLow,
    input  logic                     SC_PLAYERMOVE_rightButton_InLow,
    input  logic                     SC_PLAYERMOVE_levelReset_InHigh,
    input  logic                     SC_PLAYERMOVE_nextLevel_InHigh,
    output logic                     SC_PLAYERMOVE_clear_OutLow,
    output logic                     SC_PLAYERMOVE_load0_OutLow,
    output logic                     SC_PLAYERMOVE_load1_OutLow,
    output logic [1:0]               SC_PLAYERMOVE_shiftselection_Out,
    output logic [$clog2(ROWS)-1:0]  SC_PLAYERMOVE_row_Out,
    output logic [$clog2(COLS)-1:0]  SC_PLAYERMOVE_col_Out,
    output logic                     SC_PLAYERMOVE_reachedTop_OutHigh
);

    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam logic [RW-1:0] ROW_BOTTOM = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_RIGHT  = CW'(COLS - 1);
    localparam logic [CW-1:0] COL_START  = CW'(START_COL);

    logic startP, upP, downP, leftP, rightP, anyPressed, quitReq;
    logic capturedHeld, timerDone, timerEnable, timerClear;
    playerState_e stateQ, stateD;
    playerBtn_e heldQ, heldD, pressedBtn;
    logic [RW-1:0] rowQ, rowD;
    logic [CW-1:0] colQ, colD;
    logic clearQ, load0Q, load1Q, reachedTopQ;
    logic [1:0] shiftQ;

    assign startP     = ~SC_PLAYERMOVE_startButton_InLow;
    assign upP        = ~SC_PLAYERMOVE_upButton_InLow;
    assign downP      = ~SC_PLAYERMOVE_downButton_InLow;
    assign leftP      = ~SC_PLAYERMOVE_leftButton_InLow;
    assign rightP     = ~SC_PLAYERMOVE_rightButton_InLow;
    assign anyPressed = startP | upP | downP | leftP | rightP;
    assign quitReq    = SC_PLAYERMOVE_levelReset_InHigh | SC_PLAYERMOVE_nextLevel_InHigh;

    // A move is legal only if the registered position leaves room in that direction.
    function automatic logic legalMove(input playerBtn_e btn, input logic [RW-1:0] r,
                                       input logic [CW-1:0] c);
        logic ok;
        case (btn)
            BTN_UP:    ok = (r != '0);
            BTN_DOWN:  ok = (r != ROW_BOTTOM);
            BTN_LEFT:  ok = (c != '0);
            BTN_RIGHT: ok = (c != COL_RIGHT);
            default:   ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        pressedBtn = BTN_NONE;
        if (startP)      pressedBtn = BTN_START;
        else if (upP)    pressedBtn = BTN_UP;
        else if (downP)  pressedBtn = BTN_DOWN;
        else if (leftP)  pressedBtn = BTN_LEFT;
        else if (rightP) pressedBtn = BTN_RIGHT;
    end

    // Start is deliberately never "held" so it cannot auto-repeat.
    always_comb begin
        case (heldQ)
            BTN_UP:    capturedHeld = upP;
            BTN_DOWN:  capturedHeld = downP;
            BTN_LEFT:  capturedHeld = leftP;
            BTN_RIGHT: capturedHeld = rightP;
            default:   capturedHeld = 1'b0;
        endcase
    end

    assign timerEnable = (stateQ == HOLD) && capturedHeld;
    assign timerClear  = !timerEnable;

    sc_repeat_timer #(
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) uRepeatTimer (
        .clk_i    (SC_PLAYERMOVE_CLOCK_50),
        .rst_i    (SC_PLAYERMOVE_RESET_InHigh),
        .clear_i  (timerClear),
        .enable_i (timerEnable),
        .done_o   (timerDone)
    );

    always_comb begin
        stateD = stateQ;
        heldD  = heldQ;
        case (stateQ)
            RESET: stateD = START;
            START: stateD = CHECK;
            CHECK: begin
                if (quitReq) begin
                    stateD = RESET;
                end else if (pressedBtn != BTN_NONE) begin
                    heldD = pressedBtn;
                    if (pressedBtn == BTN_START) begin
                        stateD = INIT;
                    end else if (legalMove(pressedBtn, rowQ, colQ)) begin
                        stateD = moveState(pressedBtn);
                    end else begin
                        stateD = HOLD;
                    end
                end
            end
            INIT, UP, DOWN, LEFT, RIGHT: stateD = HOLD;
            HOLD: begin
                if (quitReq) begin
                    stateD = RESET;
                end else if (!anyPressed) begin
                    stateD = CHECK;
                end else if (capturedHeld && timerDone && legalMove(heldQ, rowQ, colQ)) begin
                    stateD = moveState(heldQ);
                end
            end
            default: stateD = RESET;
        endcase
    end

    // Position moves on the same edge that enters the command state, matching the matrix shift.
    always_comb begin
        rowD = rowQ;
        colD = colQ;
        case (stateD)
            INIT: begin
                rowD = ROW_BOTTOM;
                colD = COL_START;
            end
            UP:      rowD = rowQ - RW'(1);
            DOWN:    rowD = rowQ + RW'(1);
            LEFT:    colD = colQ - CW'(1);
            RIGHT:   colD = colQ + CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge SC_PLAYERMOVE_CLOCK_50 or posedge SC_PLAYERMOVE_RESET_InHigh) begin
        if (SC_PLAYERMOVE_RESET_InHigh) begin
            stateQ      <= RESET;
            heldQ       <= BTN_NONE;
            rowQ        <= ROW_BOTTOM;
            colQ        <= COL_START;
            clearQ      <= 1'b1;
            load0Q      <= 1'b1;
            load1Q      <= 1'b1;
            shiftQ      <= SHIFT_HOLD;
            reachedTopQ <= 1'b0;
        end else begin
            stateQ      <= stateD;
            heldQ       <= heldD;
            rowQ        <= rowD;
            colQ        <= colD;
            clearQ      <= (stateD != INIT);
            load0Q      <= (stateD != UP);
            load1Q      <= (stateD != DOWN);
            shiftQ      <= (stateD == LEFT)  ? SHIFT_LEFT :
                           (stateD == RIGHT) ? SHIFT_RIGHT : SHIFT_HOLD;
            reachedTopQ <= (stateQ == UP) && (rowQ == '0);
        end
    end

    assign SC_PLAYERMOVE_clear_OutLow       = clearQ;
    assign SC_PLAYERMOVE_load0_OutLow       = load0Q;
    assign SC_PLAYERMOVE_load1_OutLow       = load1Q;
    assign SC_PLAYERMOVE_shiftselection_Out = shiftQ;
    assign SC_PLAYERMOVE_row_Out            = rowQ;
    assign SC_PLAYERMOVE_col_Out            = colQ;
    assign SC_PLAYERMOVE_reachedTop_OutHigh = reachedTopQ;

endmodule

// File: tb/tb_sc_player_move_ctrl.sv
// Bench for sc_player_move_ctrl: a directed walk through the key scenarios followed by random button
// traffic, every cycle compared against a position/command model built from the game rules.
module tb_sc_player_move_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 8;
    localparam int START_COL = 3;
    localparam int REP = 4;

    localparam bit [4:0] B_NONE  = 5'b00000;
    localparam bit [4:0] B_START = 5'b00001;
    localparam bit [4:0] B_UP    = 5'b00010;
    localparam bit [4:0] B_DOWN  = 5'b00100;
    localparam bit [4:0] B_LEFT  = 5'b01000;
    localparam bit [4:0] B_RIGHT = 5'b10000;

    // Model phases: booting through reset, waiting for a button, one command cycle, holding.
    localparam int W_BOOT = 0;
    localparam int W_WAIT = 1;
    localparam int W_CMD  = 2;
    localparam int W_HOLD = 3;

    logic clock = 1'b0;
    logic reset;
    logic startN, upN, downN, leftN, rightN, levelReset, nextLevel;
    logic clearN, load0N, load1N, reachedTop;
    logic [1:0] shiftSel;
    logic [2:0] row, col;

    int total = 0;
    int bad = 0;

    int where, bootLeft, holdBtn, holdCnt, mRow, mCol;
    bit topArm;
    int eClear, eLoad0, eLoad1, eShift, eTop;
    bit pressed[5];
    bit lrIn, nlIn;
    int dRow[5] = '{0, -1, 1, 0, 0};
    int dCol[5] = '{0, 0, 0, -1, 1};
    int load0Pulses, topPulses;

    always #5 clock = ~clock;

    sc_player_move_ctrl #(
        .ROWS(ROWS), .COLS(COLS), .START_COL(START_COL), .REPEAT_CYCLES(REP)
    ) dut (
        .SC_PLAYERMOVE_CLOCK_50           (clock),
        .SC_PLAYERMOVE_RESET_InHigh       (reset),
        .SC_PLAYERMOVE_startButton_InLow  (startN),
        .SC_PLAYERMOVE_upButton_InLow     (upN),
        .SC_PLAYERMOVE_downButton_InLow   (downN),
        .SC_PLAYERMOVE_leftButton_InLow   (leftN),
        .SC_PLAYERMOVE_rightButton_InLow  (rightN),
        .SC_PLAYERMOVE_levelReset_InHigh  (levelReset),
        .SC_PLAYERMOVE_nextLevel_InHigh   (nextLevel),
        .SC_PLAYERMOVE_clear_OutLow       (clearN),
        .SC_PLAYERMOVE_load0_OutLow       (load0N),
        .SC_PLAYERMOVE_load1_OutLow       (load1N),
        .SC_PLAYERMOVE_shiftselection_Out (shiftSel),
        .SC_PLAYERMOVE_row_Out            (row),
        .SC_PLAYERMOVE_col_Out            (col),
        .SC_PLAYERMOVE_reachedTop_OutHigh (reachedTop)
    );

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic modelIdle();
        eClear = 1; eLoad0 = 1; eLoad1 = 1; eShift = 3; eTop = 0;
    endtask

    task automatic modelReset();
        modelIdle();
        where = W_BOOT; bootLeft = 2; holdBtn = -1; holdCnt = 0;
        mRow = ROWS - 1; mCol = START_COL; topArm = 0;
    endtask

    // Attempts a move of button b (1..4); on success updates position and the expected command.
    task automatic tryMove(input int b, output bit ok);
        int nr, nc;
        nr = mRow + dRow[b];
        nc = mCol + dCol[b];
        ok = (nr >= 0) && (nr < ROWS) && (nc >= 0) && (nc < COLS);
        if (ok) begin
            mRow = nr; mCol = nc;
            if (b == 1) eLoad0 = 0;
            if (b == 2) eLoad1 = 0;
            if (b == 3) eShift = 1;
            if (b == 4) eShift = 2;
            topArm = (b == 1) && (nr == 0);
            where = W_CMD;
        end
    endtask

    task automatic modelStep();
        int first;
        bit ok, anyP;
        modelIdle();
        eTop = topArm;
        topArm = 0;
        first = -1;
        for (int b = 4; b >= 0; b--) if (pressed[b]) first = b;
        anyP = (first >= 0);
        case (where)
            W_BOOT: begin
                bootLeft--;
                if (bootLeft == 0) where = W_WAIT;
            end
            W_CMD: begin
                where = W_HOLD; holdCnt = 0;
            end
            W_WAIT: begin
                if (lrIn || nlIn) begin
                    where = W_BOOT; bootLeft = 2;
                end else if (first == 0) begin
                    eClear = 0; mRow = ROWS - 1; mCol = START_COL;
                    holdBtn = 0; where = W_CMD;
                end else if (first > 0) begin
                    holdBtn = first;
                    tryMove(first, ok);
                    if (!ok) begin
                        where = W_HOLD; holdCnt = 0;
                    end
                end
            end
            default: begin
                if (lrIn || nlIn) begin
                    where = W_BOOT; bootLeft = 2;
                end else if (!anyP) begin
                    where = W_WAIT;
                end else if (holdBtn >= 1 && pressed[holdBtn]) begin
                    if (holdCnt == REP - 1) tryMove(holdBtn, ok);
                    else holdCnt++;
                end else begin
                    holdCnt = 0;
                end
            end
        endcase
    endtask

    task automatic applyStimulus(input bit [4:0] mask, input bit lr, input bit nl);
        for (int b = 0; b < 5; b++) pressed[b] = mask[b];
        lrIn = lr; nlIn = nl;
        startN = ~mask[0]; upN = ~mask[1]; downN = ~mask[2];
        leftN = ~mask[3]; rightN = ~mask[4];
        levelReset = lr; nextLevel = nl;
    endtask

    task automatic checkOutput();
        cmp("clear", int'(clearN), eClear);
        cmp("load0", int'(load0N), eLoad0);
        cmp("load1", int'(load1N), eLoad1);
        cmp("shiftsel", int'(shiftSel), eShift);
        cmp("row", int'(row), mRow);
        cmp("col", int'(col), mCol);
        cmp("reachedTop", int'(reachedTop), eTop);
        if (load0N == 1'b0) load0Pulses++;
        if (reachedTop) topPulses++;
    endtask

    task automatic tick(input bit [4:0] mask, input bit lr = 0, input bit nl = 0);
        applyStimulus(mask, lr, nl);
        @(posedge clock);
        modelStep();
        @(negedge clock);
        checkOutput();
    endtask

    task automatic tap(input bit [4:0] mask);
        tick(mask);
        tick(B_NONE);
        tick(B_NONE);
    endtask

    task automatic resetPulse();
        reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        @(negedge clock);
        checkOutput();
        reset = 1'b0;
    endtask

    initial begin
        bit [19:0] rightSeen;
        bit [4:0] m;
        bit didMidReset;
        int n, len, r;

        applyStimulus(B_NONE, 0, 0);
        reset = 1'b1;
        modelReset();
        @(negedge clock);
        checkOutput();
        cmp("reset row literal", int'(row), 7);
        cmp("reset col literal", int'(col), 3);
        cmp("reset shift literal", int'(shiftSel), 3);
        reset = 1'b0;

        tick(B_NONE); tick(B_NONE); tick(B_NONE);
        tick(B_UP);
        cmp("first up load0 literal", int'(load0N), 0);
        cmp("first up row literal", int'(row), 6);
        tick(B_NONE);
        cmp("after up load0 literal", int'(load0N), 1);
        tick(B_NONE);
        tap(B_DOWN);

        tick(B_DOWN);
        for (int i = 0; i < 6; i++) tick(B_DOWN);
        cmp("bottom down row literal", int'(row), 7);
        cmp("bottom down load1 literal", int'(load1N), 1);
        tick(B_NONE);

        tap(B_LEFT); tap(B_LEFT); tap(B_LEFT);
        cmp("left edge col literal", int'(col), 0);
        for (int i = 0; i < 8; i++) tick(B_LEFT);
        cmp("left edge shift literal", int'(shiftSel), 3);
        cmp("left edge col held literal", int'(col), 0);
        tick(B_NONE);

        load0Pulses = 0; topPulses = 0;
        for (int i = 0; i < 7; i++) tap(B_UP);
        cmp("climb load0 pulses literal", load0Pulses, 7);
        cmp("climb reachedTop literal", topPulses, 1);
        cmp("climb row literal", int'(row), 0);
        tap(B_UP);
        cmp("extra up load0 literal", load0Pulses, 7);
        cmp("extra up reachedTop literal", topPulses, 1);

        tick(B_START);
        cmp("init clear literal", int'(clearN), 0);
        cmp("init row literal", int'(row), 7);
        cmp("init col literal", int'(col), 3);
        tick(B_NONE); tick(B_NONE);

        rightSeen = '0;
        for (int i = 0; i < 20; i++) begin
            tick(B_RIGHT);
            if (shiftSel == 2'b10) rightSeen[i] = 1'b1;
        end
        cmp("repeat pattern literal", int'(rightSeen), 32'h08421);
        cmp("repeat col literal", int'(col), 7);

        load0Pulses = 0;
        tick(B_RIGHT | B_UP, 1, 0);
        cmp("levelReset row literal", int'(row), 7);
        cmp("levelReset col literal", int'(col), 7);
        cmp("levelReset shift literal", int'(shiftSel), 3);
        tick(B_RIGHT | B_UP);
        tick(B_NONE);
        cmp("levelReset no pulses literal", load0Pulses, 0);

        n = 0;
        didMidReset = 0;
        while (n < 4000) begin
            len = $urandom_range(1, 12);
            r = $urandom_range(0, 9);
            if (r < 4) begin
                m = B_NONE;
            end else begin
                m = 5'(1 << $urandom_range(0, 4));
                if ($urandom_range(0, 3) == 0) m = m | 5'(1 << $urandom_range(0, 4));
            end
            for (int k = 0; k < len; k++) begin
                tick(m, ($urandom_range(0, 63) == 0), ($urandom_range(0, 63) == 0));
                n++;
            end
            if (!didMidReset && n >= 2000) begin
                didMidReset = 1;
                resetPulse();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
